ifm_stream_loader: RTL

- Fills the IFM/weight DPRAM from a host byte stream before `start` is raised on the systolic top.
- It is the writer counterpart of the OFM readback path: it packs serial DATA_WIDTH bytes into INOUT_WIDTH memory words and writes them at incrementing addresses from a base.
- When the programmed byte count has been written, it raises a one-cycle done pulse.
- Sits between the host link and DPRAM write port A.

---
 rtl/ifm_stream_loader_pkg.sv | 26 ++
 rtl/ifm_stream_loader_byte_packer.sv | 53 +++++
 rtl/ifm_stream_loader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ifm_stream_loader_pkg.sv
// rtl/ifm_stream_loader_pkg.sv - shared constants, state encoding and sizing helper for the IFM stream loader
package ifm_stream_loader_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int INOUT_WIDTH = 128;
    localparam int LANES       = INOUT_WIDTH / DATA_WIDTH;
    localparam int LANE_BITS   = $clog2(LANES);
    localparam int ADDR_WIDTH  = 12;
    localparam int LEN_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of memory words a transfer of len bytes occupies (ceil(len/LANES)).
    // The sum is one bit wider so len near the top of the range cannot overflow.
    function automatic logic [LEN_WIDTH-1:0] words_for_len(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, len} + (LEN_WIDTH + 1)'(LANES - 1);
        return LEN_WIDTH'(sum >> LANE_BITS);
    endfunction

endpackage

// File: rtl/ifm_stream_loader_byte_packer.sv
// rtl/ifm_stream_loader_byte_packer.sv - packs serial bytes into one DPRAM word, LSB lane first
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   push       a byte is accepted this cycle
//   clear      discard any partial word and restart at lane 0
//   flush_pad  the current partial word is being written out; empty the register
//   data       byte to insert at the current lane
//   word       packed word including the byte being pushed this cycle
//   word_full  this push fills the last lane
module ifm_stream_loader_byte_packer
    import ifm_stream_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   clear,
    input  logic                   flush_pad,
    input  logic [DATA_WIDTH-1:0]  data,
    output logic [INOUT_WIDTH-1:0] word,
    output logic                   word_full
);

    logic [LANE_BITS-1:0]   lane;
    logic [INOUT_WIDTH-1:0] pack;

    // The word output already carries the byte being pushed, so the owner can
    // capture a completed word on the same edge that accepts its last byte.
    always_comb begin
        word = pack;
        if (push) begin
            word[lane*DATA_WIDTH +: DATA_WIDTH] = data;
        end
    end

    assign word_full = push && (lane == LANE_BITS'(LANES - 1));

    // The register is emptied after every completed or flushed word, so the
    // lanes above the fill point of a partial word are always zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= '0;
            pack <= '0;
        end else if (clear || flush_pad || word_full) begin
            lane <= '0;
            pack <= '0;
        end else if (push) begin
            lane <= lane + LANE_BITS'(1);
            pack <= word;
        end
    end

endmodule

// File: rtl/ifm_stream_loader.sv
// rtl/ifm_stream_loader.sv - writes a host byte stream into the IFM/weight DPRAM as packed words
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   load_start            begins a transfer (only honoured while idle)
//   base_addr, len_bytes  first word address and byte count, latched on load_start
//   s_data, s_valid       incoming byte stream
//   s_ready               loader accepts a byte this cycle
//   mem_we, mem_addr,     DPRAM port A write
//   mem_wdata
//   busy                  transfer in progress
//   load_done             one-cycle completion pulse
module ifm_stream_loader
    import ifm_stream_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [LEN_WIDTH-1:0]   len_bytes,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INOUT_WIDTH-1:0] mem_wdata,
    output logic                   busy,
    output logic                   load_done
);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   byte_cnt;

    logic                   push;
    logic                   last_byte;
    logic                   start_ok;
    logic                   flush_pad;
    logic [INOUT_WIDTH-1:0] word;
    logic                   word_full;

    // s_ready is a registered output, so push is a clean function of state.
    assign push      = s_valid && s_ready;
    assign last_byte = push && ((byte_cnt + LEN_WIDTH'(1)) == len_q);
    assign start_ok  = (state == ST_IDLE) && load_start;
    assign flush_pad = (state == ST_FLUSH);

    ifm_stream_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .clear     (start_ok),
        .flush_pad (flush_pad),
        .data      (s_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            byte_cnt  <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        busy <= 1'b1;
                        if (len_bytes != '0) begin
                            addr_q   <= base_addr;
                            len_q    <= len_bytes;
                            byte_cnt <= '0;
                            s_ready  <= 1'b1;
                            state    <= ST_LOAD;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (push) begin
                        byte_cnt <= byte_cnt + LEN_WIDTH'(1);
                        if (word_full) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_q;
                            mem_wdata <= word;
                            addr_q    <= addr_q + ADDR_WIDTH'(1);
                        end
                        if (last_byte) begin
                            s_ready <= 1'b0;
                            state   <= word_full ? ST_DONE : ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Packer holds the partial word with zeroed upper lanes.
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_q;
                    mem_wdata <= word;
                    addr_q    <= addr_q + ADDR_WIDTH'(1);
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    load_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
